// File: rtl/conv_seq_ctrl_if.sv
// rtl/conv_seq_ctrl_if.sv - memory read port and result port bundle for conv_seq_ctrl
//
// Purpose: groups the two handshake buses of the convolution sequencer.
//   mem_req   : read request, always granted
//   mem_addr  : read address (ADDR_W)
//   mem_rdata : read data, valid the cycle after mem_req
//   res_valid : result available
//   res_ready : sink accepts the result
//   res_data  : 16-bit result
//   res_idx   : sample index of the result (ADDR_W)
// Modports: master = sequencer side, slave = memory/sink side.

interface conv_seq_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              res_valid;
    logic              res_ready;
    logic [15:0]       res_data;
    logic [ADDR_W-1:0] res_idx;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_idx
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_idx
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// rtl/conv_seq_ctrl.sv - job sequencer for a 25-tap convolution datapath unit
//
// Purpose: per job, reads KERNEL_NUM weights, one bias and cfg_len samples
// from a 1-cycle-latency read port, strobes them into the conv unit, drops
// warm-up outputs and queues valid results in a small FIFO.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start, cfg_*             : job launch and configuration (sampled in IDLE)
//   busy, done               : job in progress / one-cycle end-of-job pulse
//   conv_in, conv_*_valid    : conv unit input bus and load strobes
//   conv_out                 : conv unit result
//   bus (master)             : memory read port and result valid/ready port

module conv_seq_ctrl #(
    parameter int KERNEL_NUM = 25,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_w_base,
    input  logic [ADDR_W-1:0] cfg_x_base,
    input  logic [ADDR_W-1:0] cfg_len,
    output logic              busy,
    output logic              done,
    output logic [15:0]       conv_in,
    output logic              conv_w_valid,
    output logic              conv_b_valid,
    output logic              conv_i_valid,
    input  logic [15:0]       conv_out,
    conv_seq_ctrl_if.master   bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam int TAG_N = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_B,
        S_STREAM,
        S_DRAIN
    } state_t;

    typedef enum logic [1:0] {
        TAG_W,
        TAG_B,
        TAG_X
    } tag_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic [ADDR_W-1:0] x_base_q, x_base_d;
    logic [ADDR_W-1:0] len_q, len_d;

    // Tag pipeline: stage 0 is the request issued last cycle (its data is on
    // mem_rdata now), stage 2 lines up with the matching conv_out.
    logic [TAG_N-1:0]  tag_valid_q, tag_valid_d;
    logic [TAG_N-1:0]  tag_keep_q, tag_keep_d;
    tag_t              tag_type_q [TAG_N];
    tag_t              tag_type_d [TAG_N];
    logic [ADDR_W-1:0] tag_idx_q [TAG_N];
    logic [ADDR_W-1:0] tag_idx_d [TAG_N];

    logic [15:0]       fifo_data_q [FIFO_DEPTH];
    logic [15:0]       fifo_data_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_idx_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;

    logic              req;
    logic [ADDR_W-1:0] req_addr;
    tag_t              req_type;
    logic              req_keep;
    logic [ADDR_W-1:0] req_idx;
    logic              job_done;
    logic [SUM_W-1:0]  kept_in_flight;
    logic              credit_ok;
    logic              in_flight;
    logic              push;
    logic              pop;
    logic              fifo_nonempty;

    // Results already promised to the FIFO (kept tags still in the pipeline)
    // count against free space so a push can never find the FIFO full.
    always_comb begin
        kept_in_flight = '0;
        for (int i = 0; i < TAG_N; i++) begin
            kept_in_flight = kept_in_flight + SUM_W'(tag_valid_q[i] & tag_keep_q[i]);
        end
        credit_ok = (SUM_W'(fifo_cnt_q) + kept_in_flight) < SUM_W'(FIFO_DEPTH);
        in_flight = |tag_valid_q;
    end

    // Sequencer next-state and request generation
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_base_d = w_base_q;
        x_base_d = x_base_q;
        len_d    = len_q;
        req      = 1'b0;
        req_addr = '0;
        req_type = TAG_W;
        req_keep = 1'b0;
        req_idx  = '0;
        job_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_base_d = cfg_w_base;
                    x_base_d = cfg_x_base;
                    len_d    = cfg_len;
                    cnt_d    = '0;
                    state_d  = S_LOAD_W;
                end
            end

            S_LOAD_W: begin
                req      = 1'b1;
                req_addr = w_base_q + cnt_q;
                req_type = TAG_W;
                if (cnt_q == ADDR_W'(KERNEL_NUM - 1)) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_B;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            S_LOAD_B: begin
                req      = 1'b1;
                req_addr = w_base_q + ADDR_W'(KERNEL_NUM);
                req_type = TAG_B;
                state_d  = (len_q == '0) ? S_DRAIN : S_STREAM;
            end

            S_STREAM: begin
                if (credit_ok) begin
                    req      = 1'b1;
                    req_addr = x_base_q + cnt_q;
                    req_type = TAG_X;
                    // Outputs before the taps are fully populated are garbage.
                    req_keep = (cnt_q >= ADDR_W'(KERNEL_NUM - 1));
                    req_idx  = cnt_q;
                    if (cnt_q == len_q - ADDR_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (!in_flight && (fifo_cnt_q == '0)) begin
                    job_done = 1'b1;
                    state_d  = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Tag shift register
    always_comb begin
        tag_valid_d[0] = req;
        tag_keep_d[0]  = req_keep;
        tag_type_d[0]  = req_type;
        tag_idx_d[0]   = req_idx;
        for (int i = 1; i < TAG_N; i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_keep_d[i]  = tag_keep_q[i-1];
            tag_type_d[i]  = tag_type_q[i-1];
            tag_idx_d[i]   = tag_idx_q[i-1];
        end
    end

    // Result FIFO
    always_comb begin
        fifo_nonempty = (fifo_cnt_q != '0);
        push          = tag_valid_q[TAG_N-1] & tag_keep_q[TAG_N-1];
        pop           = fifo_nonempty & bus.res_ready;
        fifo_data_d   = fifo_data_q;
        fifo_idx_d    = fifo_idx_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        fifo_cnt_d    = fifo_cnt_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = conv_out;
            fifo_idx_d[wr_ptr_q]  = tag_idx_q[TAG_N-1];
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            w_base_q    <= '0;
            x_base_q    <= '0;
            len_q       <= '0;
            tag_valid_q <= '0;
            tag_keep_q  <= '0;
            for (int i = 0; i < TAG_N; i++) begin
                tag_type_q[i] <= TAG_W;
                tag_idx_q[i]  <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data_q[i] <= '0;
                fifo_idx_q[i]  <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            w_base_q    <= w_base_d;
            x_base_q    <= x_base_d;
            len_q       <= len_d;
            tag_valid_q <= tag_valid_d;
            tag_keep_q  <= tag_keep_d;
            tag_type_q  <= tag_type_d;
            tag_idx_q   <= tag_idx_d;
            fifo_data_q <= fifo_data_d;
            fifo_idx_q  <= fifo_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = job_done;
    assign bus.mem_req  = req;
    assign bus.mem_addr = req_addr;
    assign conv_in      = bus.mem_rdata;
    assign conv_w_valid = tag_valid_q[0] && (tag_type_q[0] == TAG_W);
    assign conv_b_valid = tag_valid_q[0] && (tag_type_q[0] == TAG_B);
    assign conv_i_valid = tag_valid_q[0] && (tag_type_q[0] == TAG_X);
    assign bus.res_valid = fifo_nonempty;
    assign bus.res_data  = fifo_nonempty ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.res_idx   = fifo_nonempty ? fifo_idx_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb/tb_conv_seq_ctrl.sv - self-checking bench for conv_seq_ctrl

module tb_conv_seq_ctrl;

    localparam int KN = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] cfg_w_base;
    logic [15:0] cfg_x_base;
    logic [15:0] cfg_len;
    logic        busy;
    logic        done;
    logic [15:0] conv_in;
    logic        conv_w_valid;
    logic        conv_b_valid;
    logic        conv_i_valid;
    logic [15:0] conv_out;

    conv_seq_ctrl_if #(.ADDR_W(16)) bus ();

    conv_seq_ctrl #(.KERNEL_NUM(KN), .ADDR_W(16), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_w_base   (cfg_w_base),
        .cfg_x_base   (cfg_x_base),
        .cfg_len      (cfg_len),
        .busy         (busy),
        .done         (done),
        .conv_in      (conv_in),
        .conv_w_valid (conv_w_valid),
        .conv_b_valid (conv_b_valid),
        .conv_i_valid (conv_i_valid),
        .conv_out     (conv_out),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Feature SRAM: one-cycle read latency
    logic [15:0] tb_mem [0:511];
    always @(posedge clk) begin
        if (bus.mem_req) bus.mem_rdata <= tb_mem[bus.mem_addr[8:0]];
    end

    // Conv unit: weight shift chain, transposed accumulator chain, output reg
    logic [15:0] wt [KN];
    logic [15:0] acc [KN];
    logic [15:0] bias_r;
    always @(posedge clk) begin
        if (conv_w_valid) begin
            for (int i = KN - 1; i > 0; i--) wt[i] <= wt[i-1];
            wt[0] <= conv_in;
        end
        if (conv_b_valid) bias_r <= conv_in;
        if (conv_i_valid) begin
            for (int i = 0; i < KN - 1; i++) acc[i] <= acc[i+1] + wt[i] * conv_in;
            acc[KN-1] <= wt[KN-1] * conv_in;
        end
        conv_out <= acc[0] + bias_r;
    end

    typedef struct {
        logic [15:0] data;
        logic [15:0] idx;
    } exp_t;
    exp_t exp_q[$];

    int pass_cnt = 0;
    int check_cnt = 0;
    int w_cnt = 0, b_cnt = 0, i_cnt = 0, done_cnt = 0, rv_cnt = 0, pop_cnt = 0;
    int w0, b0, i0, d0, r0, p0;
    int ready_mode = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One clock: sample DUT on the falling edge, then drive inputs after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (conv_w_valid) w_cnt++;
            if (conv_b_valid) b_cnt++;
            if (conv_i_valid) i_cnt++;
            if (bus.res_valid) rv_cnt++;
            if (done) begin
                done_cnt++;
                check_val("busy_at_done", 32'(busy), 32'd1);
            end
            if (bus.res_valid && bus.res_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_result", 32'(bus.res_idx), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_val("res_data", 32'(bus.res_data), 32'(e.data));
                    check_val("res_idx", 32'(bus.res_idx), 32'(e.idx));
                end
            end
        end
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       bus.res_ready = 1'b0;
            1:       bus.res_ready = 1'b1;
            default: bus.res_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic start_job(input logic [15:0] wb, input logic [15:0] xb, input logic [15:0] len);
        logic [15:0] y;
        for (int n = KN - 1; n < int'(len); n++) begin
            y = tb_mem[int'(wb) + KN];
            for (int k = 0; k < KN; k++) y = y + tb_mem[int'(wb) + k] * tb_mem[int'(xb) + n - (KN - 1) + k];
            exp_q.push_back('{data: y, idx: 16'(n)});
        end
        w0 = w_cnt; b0 = b_cnt; i0 = i_cnt; d0 = done_cnt; r0 = rv_cnt; p0 = pop_cnt;
        cfg_w_base = wb;
        cfg_x_base = xb;
        cfg_len    = len;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic finish_job(input string tag, input int exp_i, input int exp_res);
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt != d0) break;
            tick();
        end
        check_val({tag, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        repeat (4) tick();
        check_val({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check_val({tag, "_w_strobes"}, 32'(w_cnt - w0), 32'd25);
        check_val({tag, "_b_strobes"}, 32'(b_cnt - b0), 32'd1);
        check_val({tag, "_i_strobes"}, 32'(i_cnt - i0), 32'(exp_i));
        check_val({tag, "_results"}, 32'(pop_cnt - p0), 32'(exp_res));
        check_val({tag, "_left_in_queue"}, 32'(exp_q.size()), 32'd0);
        check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
        if (exp_res == 0) check_val({tag, "_no_res_valid"}, 32'(rv_cnt - r0), 32'd0);
        exp_q.delete();
    endtask

    int d_pre;
    int mreq_seen;

    initial begin
        rst = 1'b1; start = 1'b0;
        cfg_w_base = '0; cfg_x_base = '0; cfg_len = '0;
        bus.res_ready = 1'b0;
        for (int a = 0; a < 512; a++) tb_mem[a] = '0;
        // Set A at 0: all-ones weights, bias 0. Set B at 32: only W[24]=1, bias 5.
        for (int k = 0; k < KN; k++) tb_mem[k] = 16'd1;
        tb_mem[KN] = 16'd0;
        tb_mem[32 + 24] = 16'd1;
        tb_mem[32 + KN] = 16'd5;
        // Set C at 64: random small weights and bias.
        for (int k = 0; k <= KN; k++) tb_mem[64 + k] = 16'($urandom_range(0, 15));
        for (int n = 0; n < 30; n++) tb_mem[100 + n] = 16'(n + 1);
        for (int n = 0; n < 26; n++) tb_mem[200 + n] = 16'(100 + n);
        for (int n = 0; n < 40; n++) tb_mem[300 + n] = 16'($urandom);

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_val("rst_strobes", 32'({conv_w_valid, conv_b_valid, conv_i_valid}), 32'd0);
        check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_val("rst_res_data", 32'(bus.res_data), 32'd0);
        check_val("rst_res_idx", 32'(bus.res_idx), 32'd0);
        rst = 1'b0;
        ready_mode = 1;
        tick();

        // Sum of 25 consecutive samples
        start_job(16'd0, 16'd100, 16'd30);
        check_val("t1_busy_after_start", 32'(busy), 32'd1);
        finish_job("t1", 30, 6);

        // Load order and bias; first request goes to w_base
        start_job(16'd32, 16'd200, 16'd26);
        check_val("t2_first_addr", 32'(bus.mem_addr), 32'd32);
        check_val("t2_first_req", 32'(bus.mem_req), 32'd1);
        finish_job("t2", 26, 2);

        // Backpressure: FIFO fills, memory requests stall
        ready_mode = 0;
        start_job(16'd0, 16'd100, 16'd30);
        repeat (100) tick();
        check_val("stall_i_strobes", 32'(i_cnt - i0), 32'd28);
        check_val("stall_res_valid", 32'(bus.res_valid), 32'd1);
        mreq_seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.mem_req) mreq_seen = 1;
            tick();
        end
        check_val("stall_mem_req", 32'(mreq_seen), 32'd0);
        check_val("stall_busy", 32'(busy), 32'd1);
        ready_mode = 1;
        finish_job("stall", 30, 6);

        // Fewer samples than taps, and an empty stream
        start_job(16'd0, 16'd100, 16'd10);
        finish_job("short", 10, 0);
        start_job(16'd0, 16'd100, 16'd0);
        finish_job("empty", 0, 0);

        // start during STREAM is ignored; then back-to-back with new weights
        start_job(16'd0, 16'd100, 16'd30);
        repeat (35) tick();
        cfg_w_base = 16'd32; cfg_x_base = 16'd200; cfg_len = 16'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_job("ignore_start", 30, 6);
        start_job(16'd32, 16'd200, 16'd26);
        finish_job("b2b", 26, 2);

        // Random weights/samples with random sink readiness
        ready_mode = 2;
        start_job(16'd64, 16'd300, 16'd40);
        finish_job("rand", 40, 16);
        ready_mode = 1;

        // Reset mid-STREAM aborts without done; next job is clean
        start_job(16'd0, 16'd100, 16'd30);
        repeat (35) tick();
        d_pre = done_cnt;
        rst = 1'b1;
        #1;
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
        check_val("mid_rst_strobes", 32'({conv_w_valid, conv_b_valid, conv_i_valid}), 32'd0);
        check_val("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_val("mid_rst_done", 32'(done), 32'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        check_val("mid_rst_no_done", 32'(done_cnt - d_pre), 32'd0);
        check_val("mid_rst_idle", 32'(busy), 32'd0);
        start_job(16'd32, 16'd200, 16'd26);
        finish_job("after_rst", 26, 2);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer for one 25-tap convolution datapath unit (shared 16-bit `in` bus with `w_valid`, `b_valid` and `i_valid` strobes; `out` is tap-0 accumulator + bias).
- Per job: fetches weights, bias and a sample stream from a 1-cycle-latency read port, drives the unit, discards warm-up outputs and buffers valid results in a small FIFO behind a valid/ready result port.
- Sits between the layer scheduler (start/config) and local feature SRAM.

Parameters:
- KERNEL_NUM, 25, taps in the conv unit; weights loaded per job.
- ADDR_W, 16, memory address and length width.
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥4).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  job launch; sampled only in IDLE.
- cfg_w_base  in  ADDR_W  address of first weight; bias at cfg_w_base+KERNEL_NUM.
- cfg_x_base  in  ADDR_W  address of first sample.
- cfg_len  in  ADDR_W  number of samples N.
- busy  out  1  high from the cycle after accepted start until the done cycle (inclusive).
- done  out  1  one-cycle pulse at job end.
- mem_req  out  1  read request; always granted.
- mem_addr  out  ADDR_W  read address.
- mem_rdata  in  16  read data, valid the cycle after mem_req.
- conv_in  out  16  mem_rdata passed through combinationally.
- conv_w_valid / conv_b_valid / conv_i_valid  out  1 each  strobes, registered from the request-type tag.
- conv_out  in  16  conv unit result.
- res_valid  out  1  FIFO not empty.
- res_ready  in  1  sink accepts.
- res_data  out  16  result.
- res_idx  out  ADDR_W  sample index n of result.

Behaviour:
- Reset: FSM=IDLE; busy, done, mem_req, all conv strobes, res_valid = 0; mem_addr, res_data, res_idx = 0; FIFO emptied; pipeline tags cleared. Reset mid-job aborts immediately; no done pulse.
- FSM states: IDLE → LOAD_W → LOAD_B → STREAM → DRAIN → IDLE.
  - IDLE: start=1 latches cfg → LOAD_W.
  - LOAD_W: KERNEL_NUM consecutive requests, w_base+0..+24, one per cycle → LOAD_B.
  - LOAD_B: one request at w_base+25 → STREAM; if N=0 → DRAIN.
  - STREAM: request x_base+n, n=0..N-1 in order, issued only when credit allows → DRAIN after last issue.
  - DRAIN: wait for in-flight tags to retire and the FIFO to empty. Then assert done (1 cycle) with busy still high → IDLE.
- start while not IDLE: ignored.
- Strobe timing: request at cycle c; mem_rdata and the matching strobe at c+1.
  - Weight loaded k-th (address w_base+k) ends in tap 24-k. Hence y[n] = bias + Σ_k W[k]·x[n-24+k].
- Result timing: sample strobed at c+1 has its conv_out at c+3; captured into the FIFO at c+3. Total request→push = 3 cycles.
- Warm-up: samples n < KERNEL_NUM-1 are streamed but their results are not pushed. Results start at n=24.
  - N < KERNEL_NUM → zero results, done still pulses.
- Tag pipeline: 3-stage shift register {valid, type(W/B/X), keep, idx}.
- Credit: in STREAM, issue only if fifo_count + kept_in_flight < FIFO_DEPTH. Otherwise hold mem_req=0 and hold n.
- FIFO: simultaneous push and pop allowed when full-minus-pop. Pop when res_valid & res_ready. Overflow is impossible by construction; order is preserved.
- Arithmetic: conv_out forwarded unmodified (16-bit wrap in the unit); idx is ADDR_W unsigned.
- Accumulator stale state from a previous job is flushed by warm-up; no clear needed.

Test Plan:
- W[k]=1 for all k, bias=0, x[n]=n+1, N=30, res_ready=1 → 6 results: (idx24, 325), (25, 350), … (29, 450). done pulses 3+ cycles after last push.
- W[24]=1, others 0, bias=5, x[n]=100+n, N=26 → (24, 129), (25, 130). Confirms load order and bias.
- Same job as the first with res_ready=0 until mem stalls → exactly FIFO_DEPTH results held, mem_req stays 0. Release → all 6 results delivered in order, none lost or duplicated.
- N=10 → 25 W strobes, 1 B strobe, 10 I strobes, no res_valid, single done pulse. N=0 → no I strobes, done.
- start pulsed during STREAM → ignored, cfg unchanged. Back-to-back job with new weights → first result matches new weights only.
- rst asserted mid-STREAM → all outputs reset within the same cycle, no done. The next job runs correctly.
